// File: rtl/game_pkg.sv
// Shared game definitions: character state codes, frame-state codes, winner codes
// and the internal FSM encodings of the penalty controller.
package game_pkg;

  localparam int unsigned STUN_W  = 6;
  localparam int unsigned ROUND_W = 12;

  // Character FSM states (S_STUN is forced by the stunned outputs)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_ATTACK = 3'd2,
    S_BLOCK  = 3'd3,
    S_STUN   = 3'd4
  } char_state_t;

  // Frame states reported by the collision checker (2'b11 behaves as S_NOHIT)
  typedef enum logic [1:0] {
    S_NOHIT     = 2'b00,
    S_HITSTUN   = 2'b01,
    S_BLOCKSTUN = 2'b10
  } frame_state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_CHAR1 = 2'b01,
    WIN_CHAR2 = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    P_ACTIVE    = 2'd0,
    P_HITSTUN   = 2'd1,
    P_BLOCKSTUN = 2'd2,
    P_KO        = 2'd3
  } player_state_t;

  typedef enum logic {
    T_RUNNING = 1'b0,
    T_OVER    = 1'b1
  } top_state_t;

  // True for every code that does not request a penalty
  function automatic logic is_nohit(input logic [1:0] fs);
    return (fs != S_HITSTUN) && (fs != S_BLOCKSTUN);
  endfunction

endpackage

// File: rtl/player_penalty_fsm.sv
// Per-character penalty sequencer: NOHIT->HIT/BLOCK edge detection, stun frame
// countdown, health deduction with saturation at zero, and KO detection.
module player_penalty_fsm
  import game_pkg::*;
#(
  parameter int unsigned         HEALTH_W         = 3,
  parameter logic [HEALTH_W-1:0] HEALTH_MAX       = HEALTH_W'(3),
  parameter logic [HEALTH_W-1:0] HIT_DAMAGE       = HEALTH_W'(1),
  parameter logic [STUN_W-1:0]   HITSTUN_FRAMES   = STUN_W'(15),
  parameter logic [STUN_W-1:0]   BLOCKSTUN_FRAMES = STUN_W'(8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                round_start,
  input  logic                running,
  input  logic [1:0]          frame_state,
  output logic                stunned,
  output logic [HEALTH_W-1:0] health,
  output logic                hit,
  output logic                ko
);

  player_state_t       state;
  logic [1:0]          prev_state;
  logic [STUN_W-1:0]   stun_cnt;
  logic                accept_c;
  logic [HEALTH_W-1:0] health_dmg_c;

  // A penalty is taken only on a fresh edge while the player is free and the round is live
  assign accept_c = is_nohit(prev_state) && !is_nohit(frame_state) &&
                    running && (state == P_ACTIVE);

  // Health after one hit, saturating at zero
  assign health_dmg_c = (health > HIT_DAMAGE) ? (health - HIT_DAMAGE) : '0;

  // Player state, stun counter, health and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= P_ACTIVE;
      prev_state <= S_NOHIT;
      stun_cnt   <= '0;
      health     <= HEALTH_MAX;
      stunned    <= 1'b0;
      hit        <= 1'b0;
      ko         <= 1'b0;
    end else if (round_start) begin
      state      <= P_ACTIVE;
      prev_state <= S_NOHIT;
      stun_cnt   <= '0;
      health     <= HEALTH_MAX;
      stunned    <= 1'b0;
      hit        <= 1'b0;
      ko         <= 1'b0;
    end else begin
      prev_state <= frame_state;
      hit        <= 1'b0;
      case (state)
        P_ACTIVE: begin
          if (accept_c) begin
            hit     <= 1'b1;
            stunned <= 1'b1;
            if (frame_state == S_HITSTUN) begin
              health <= health_dmg_c;
              if (health_dmg_c == '0) begin
                state <= P_KO;
                ko    <= 1'b1;
              end else begin
                state    <= P_HITSTUN;
                stun_cnt <= HITSTUN_FRAMES;
              end
            end else begin
              state    <= P_BLOCKSTUN;
              stun_cnt <= BLOCKSTUN_FRAMES;
            end
          end
        end
        P_HITSTUN, P_BLOCKSTUN: begin
          // Countdown freezes once the round is over
          if (running && frame_tick) begin
            if (stun_cnt == STUN_W'(1)) begin
              state    <= P_ACTIVE;
              stunned  <= 1'b0;
              stun_cnt <= '0;
            end else begin
              stun_cnt <= stun_cnt - STUN_W'(1);
            end
          end
        end
        default: begin
          // KO holds stunned high until the next round
        end
      endcase
    end
  end

endmodule

// File: rtl/hit_penalty_controller.sv
// Hit penalty controller: two player penalty sequencers, the RUNNING/OVER round
// FSM and winner resolution. Optional round timer enabled by ROUND_TIMER_EN.
module hit_penalty_controller
  import game_pkg::*;
#(
  parameter int unsigned         HEALTH_W         = 3,
  parameter logic [HEALTH_W-1:0] HEALTH_MAX       = HEALTH_W'(3),
  parameter logic [HEALTH_W-1:0] HIT_DAMAGE       = HEALTH_W'(1),
  parameter logic [STUN_W-1:0]   HITSTUN_FRAMES   = STUN_W'(15),
  parameter logic [STUN_W-1:0]   BLOCKSTUN_FRAMES = STUN_W'(8)
`ifdef ROUND_TIMER_EN
  ,
  parameter logic [ROUND_W-1:0]  ROUND_FRAMES     = ROUND_W'(3600)
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                round_start,
  input  logic [1:0]          char1_frame_state,
  input  logic [1:0]          char2_frame_state,
  output logic                char1_stunned,
  output logic                char2_stunned,
  output logic [HEALTH_W-1:0] char1_health,
  output logic [HEALTH_W-1:0] char2_health,
  output logic [1:0]          hit_pulse,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic [ROUND_W-1:0]  round_frames_left
);

  top_state_t state;
  logic       running;
  logic       hit1;
  logic       hit2;
  logic       ko1;
  logic       ko2;

  assign running   = (state == T_RUNNING);
  assign hit_pulse = {hit2, hit1};

  player_penalty_fsm #(
    .HEALTH_W         (HEALTH_W),
    .HEALTH_MAX       (HEALTH_MAX),
    .HIT_DAMAGE       (HIT_DAMAGE),
    .HITSTUN_FRAMES   (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
  ) u_char1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .round_start (round_start),
    .running     (running),
    .frame_state (char1_frame_state),
    .stunned     (char1_stunned),
    .health      (char1_health),
    .hit         (hit1),
    .ko          (ko1)
  );

  player_penalty_fsm #(
    .HEALTH_W         (HEALTH_W),
    .HEALTH_MAX       (HEALTH_MAX),
    .HIT_DAMAGE       (HIT_DAMAGE),
    .HITSTUN_FRAMES   (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
  ) u_char2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .round_start (round_start),
    .running     (running),
    .frame_state (char2_frame_state),
    .stunned     (char2_stunned),
    .health      (char2_health),
    .hit         (hit2),
    .ko          (ko2)
  );

`ifdef ROUND_TIMER_EN
  logic [ROUND_W-1:0] timer;
  assign round_frames_left = timer;
`else
  assign round_frames_left = '0;
`endif

  // Round FSM: KO (or timeout) ends the round, only round_start reopens it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= T_RUNNING;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
`ifdef ROUND_TIMER_EN
      timer     <= ROUND_FRAMES;
`endif
    end else if (round_start) begin
      state     <= T_RUNNING;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
`ifdef ROUND_TIMER_EN
      timer     <= ROUND_FRAMES;
`endif
    end else if (state == T_RUNNING) begin
      if (ko1 || ko2) begin
        // The surviving player wins; a double KO is a draw
        state     <= T_OVER;
        game_over <= 1'b1;
        if (ko1 && ko2)  winner <= WIN_DRAW;
        else if (ko1)    winner <= WIN_CHAR2;
        else             winner <= WIN_CHAR1;
      end
`ifdef ROUND_TIMER_EN
      else if (frame_tick && (timer != '0)) begin
        timer <= timer - ROUND_W'(1);
        if (timer == ROUND_W'(1)) begin
          state     <= T_OVER;
          game_over <= 1'b1;
          if (char1_health > char2_health)      winner <= WIN_CHAR1;
          else if (char2_health > char1_health) winner <= WIN_CHAR2;
          else                                  winner <= WIN_DRAW;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_hit_penalty_controller.sv
// Directed bench for hit_penalty_controller: per-cycle vector table plus
// hand sequences for asynchronous reset and (with ROUND_TIMER_EN) the round timer.
module tb_hit_penalty_controller;

  typedef struct packed {
    logic       rs;
    logic       tick;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       st1;
    logic       st2;
    logic [2:0] h1;
    logic [2:0] h2;
    logic [1:0] pulse;
    logic       go;
    logic [1:0] win;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        round_start = 1'b0;
  logic [1:0]  s1 = 2'b00;
  logic [1:0]  s2 = 2'b00;
  logic        st1, st2, go;
  logic [2:0]  h1, h2;
  logic [1:0]  pulse, win;
  logic [11:0] rfl;

  int n_applied = 0;
  int n_miscomp = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  hit_penalty_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .round_start       (round_start),
    .char1_frame_state (s1),
    .char2_frame_state (s2),
    .char1_stunned     (st1),
    .char2_stunned     (st2),
    .char1_health      (h1),
    .char2_health      (h2),
    .hit_pulse         (pulse),
    .game_over         (go),
    .winner            (win),
    .round_frames_left (rfl)
  );

`ifdef ROUND_TIMER_EN
  localparam logic [11:0] RFL_RESET = 12'd3600;
  logic        t_tick = 1'b0;
  logic        t_rs = 1'b0;
  logic [1:0]  t_s1 = 2'b00;
  logic [1:0]  t_s2 = 2'b00;
  logic        t_st1, t_st2, t_go;
  logic [2:0]  t_h1, t_h2;
  logic [1:0]  t_pulse, t_win;
  logic [11:0] t_rfl;

  hit_penalty_controller #(.ROUND_FRAMES(12'd4)) dut_t (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (t_tick),
    .round_start       (t_rs),
    .char1_frame_state (t_s1),
    .char2_frame_state (t_s2),
    .char1_stunned     (t_st1),
    .char2_stunned     (t_st2),
    .char1_health      (t_h1),
    .char2_health      (t_h2),
    .hit_pulse         (t_pulse),
    .game_over         (t_go),
    .winner            (t_win),
    .round_frames_left (t_rfl)
  );

  task automatic t_step(input logic rs, input logic tick, input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    t_rs = rs; t_tick = tick; t_s1 = a; t_s2 = b;
    @(posedge clk);
    #1;
  endtask
`else
  localparam logic [11:0] RFL_RESET = 12'd0;
`endif

  function automatic void add(input int rs, input int tick, input int a, input int b,
                              input int e_st1, input int e_st2, input int e_h1, input int e_h2,
                              input int e_p, input int e_go, input int e_win);
    vec_t v;
    v.rs = 1'(rs);      v.tick = 1'(tick);  v.s1 = 2'(a);      v.s2 = 2'(b);
    v.st1 = 1'(e_st1);  v.st2 = 1'(e_st2);  v.h1 = 3'(e_h1);   v.h2 = 3'(e_h2);
    v.pulse = 2'(e_p);  v.go = 1'(e_go);    v.win = 2'(e_win);
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    round_start = v.rs; frame_tick = v.tick; s1 = v.s1; s2 = v.s2;
    @(posedge clk);
    #1;
    n_applied++;
    if ({st1, st2, h1, h2, pulse, go, win} !== {v.st1, v.st2, v.h1, v.h2, v.pulse, v.go, v.win}) begin
      n_miscomp++;
      $display("FAIL row %0d: st=%b%b h=%0d/%0d pulse=%b go=%b win=%b, expected st=%b%b h=%0d/%0d pulse=%b go=%b win=%b",
               idx, st1, st2, h1, h2, pulse, go, win,
               v.st1, v.st2, v.h1, v.h2, v.pulse, v.go, v.win);
    end
  endtask

  initial begin
    // Columns: rs tick s1 s2 | st1 st2 h1 h2 pulse go win
    add(0,0,0,0, 0,0,3,3,0,0,0);
    add(0,0,0,1, 0,1,3,2,2,0,0);                          // char2 hit edge
    for (int i = 0; i < 9; i++) add(0,0,0,1, 0,1,3,2,0,0,0); // held level: no retrigger
    for (int i = 1; i <= 15; i++) add(0,1,0,0, 0,(i<15)?1:0,3,2,0,0,0);
    add(0,0,2,0, 1,0,3,2,1,0,0);                          // char1 block
    add(0,0,0,0, 1,0,3,2,0,0,0);
    add(0,0,1,0, 1,0,3,2,0,0,0);                          // hit edge during blockstun ignored
    add(0,0,0,0, 1,0,3,2,0,0,0);
    for (int i = 1; i <= 8; i++) add(0,1,0,0, (i<8)?1:0,0,3,2,0,0,0);
    add(1,0,1,0, 0,0,3,3,0,0,0);                          // round_start beats a hit edge
    add(0,0,0,0, 0,0,3,3,0,0,0);
    for (int k = 1; k <= 3; k++) begin                    // three spaced hits KO char2
      add(0,0,0,1, 0,1,3,3-k,2,0,0);
      add(0,0,0,0, 0,1,3,3-k,0,(k==3)?1:0,(k==3)?1:0);
      if (k < 3) for (int i = 1; i <= 15; i++) add(0,1,0,0, 0,(i<15)?1:0,3,3-k,0,0,0);
    end
    add(0,0,1,0, 0,1,3,0,0,1,1);                          // inputs ignored while over
    add(0,1,0,1, 0,1,3,0,0,1,1);
    add(0,1,0,0, 0,1,3,0,0,1,1);
    add(1,0,0,0, 0,0,3,3,0,0,0);
    for (int k = 1; k <= 3; k++) begin                    // simultaneous hits, double KO
      add(0,0,1,1, 1,1,3-k,3-k,3,0,0);
      add(0,0,0,0, 1,1,3-k,3-k,0,(k==3)?1:0,(k==3)?3:0);
      if (k < 3) for (int i = 1; i <= 15; i++) add(0,1,0,0, (i<15)?1:0,(i<15)?1:0,3-k,3-k,0,0,0);
    end
    add(1,0,0,0, 0,0,3,3,0,0,0);

    // Values while reset is held
    #12;
    chk("reset_st",     32'({st1, st2}), 32'd0);
    chk("reset_health", 32'({h1, h2}), 32'({3'd3, 3'd3}));
    chk("reset_pulse",  32'(pulse), 32'd0);
    chk("reset_over",   32'({go, win}), 32'd0);
    chk("reset_rfl",    32'(rfl), 32'(RFL_RESET));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    // Asynchronous reset in the middle of a hitstun
    apply(-1, '{rs:0, tick:0, s1:0, s2:1, st1:0, st2:1, h1:3, h2:2, pulse:2, go:0, win:0});
    apply(-2, '{rs:0, tick:1, s1:0, s2:0, st1:0, st2:1, h1:3, h2:2, pulse:0, go:0, win:0});
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("async_rst_st",     32'({st1, st2}), 32'd0);
    chk("async_rst_health", 32'({h1, h2}), 32'({3'd3, 3'd3}));
    chk("async_rst_pulse",  32'({pulse, go, win}), 32'd0);
    chk("async_rst_rfl",    32'(rfl), 32'(RFL_RESET));
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ROUND_TIMER_EN
    // Four-frame round ends on time with health 3/2
    t_step(1, 0, 2'b00, 2'b00);
    chk("timer_start", 32'(t_rfl), 32'd4);
    t_step(0, 0, 2'b00, 2'b01);
    chk("timer_hit_h2", 32'(t_h2), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      t_step(0, 1, 2'b00, 2'b00);
      chk("timer_rfl", 32'(t_rfl), 32'(4 - i));
      chk("timer_go",  32'(t_go), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("timer_winner", 32'(t_win), 32'd1);
    t_step(0, 1, 2'b01, 2'b00);
    chk("timer_frozen", 32'({t_go, t_win, t_rfl}), 32'({1'b1, 2'b01, 12'd0}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
    $finish;
  end

endmodule
